// File: rtl/fifo_wr_skid.sv
`timescale 1ns/1ps
// fifo_wr_skid: 2-entry skid buffer in front of the write port of an async FIFO.
// Latency: a word accepted at edge N is on wdata after N and can be written at N+1.
// Backpressure: s_ready is registered and drops only when both entries are full.
//
// Ports:
//   wclk, w_rstn            write-domain clock, async active-low reset
//   s_valid/s_data/s_ready  upstream valid-ready handshake
//   winc/wdata/wfull        FIFO write port (wfull may change asynchronously to wclk)
//   busy                    buffer holds at least one word
//   clr_stats               synchronous clear of the statistics counters
//   wr_cnt/stall_cnt        saturating statistics counters
//
// Macro WR_STATS_EN enables the statistics counters; when undefined the
// counter outputs are tied to 0 and clr_stats is ignored.
module fifo_wr_skid #(
  parameter int DATESIZE = 8,
  parameter int CNTW     = 16
) (
  input  logic                wclk,
  input  logic                w_rstn,
  input  logic                s_valid,
  input  logic [DATESIZE-1:0] s_data,
  output logic                s_ready,
  output logic                winc,
  output logic [DATESIZE-1:0] wdata,
  input  logic                wfull,
  output logic                busy,
  input  logic                clr_stats,
  output logic [CNTW-1:0]     wr_cnt,
  output logic [CNTW-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [DATESIZE-1:0] buf0;   // oldest word, drives wdata
  logic [DATESIZE-1:0] buf1;   // second word, only valid in TWO
  logic                accept;
  logic                write;

  // The FIFO gates its own write with wfull at the same edge, so a write is
  // counted exactly when the FIFO takes it. winc itself never looks at wfull.
  assign accept = s_valid & s_ready;
  assign write  = winc & ~wfull;
  assign wdata  = buf0;

  // s_ready, winc and busy are registered copies of the next-state decode.
  always_ff @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      state   <= EMPTY;
      s_ready <= 1'b1;
      winc    <= 1'b0;
      busy    <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state   <= ONE;
            buf0    <= s_data;
            s_ready <= 1'b1;
            winc    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !write) begin
            state   <= TWO;
            buf1    <= s_data;
            s_ready <= 1'b0;
          end else if (write && !accept) begin
            state   <= EMPTY;
            winc    <= 1'b0;
            busy    <= 1'b0;
          end else if (accept && write) begin
            // Head leaves while the new word takes its place.
            buf0    <= s_data;
          end
        end
        TWO: begin
          if (write) begin
            state   <= ONE;
            buf0    <= buf1;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          s_ready <= 1'b1;
          winc    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef WR_STATS_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // clr_stats wins over an increment at the same edge; both counters stick at max.
  always_ff @(posedge wclk or negedge w_rstn) begin
    if (!w_rstn) begin
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else if (clr_stats) begin
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (write && (wr_cnt != CNT_MAX))
        wr_cnt <= wr_cnt + CNT_ONE;
      if (winc && wfull && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end
`else
  assign wr_cnt    = '0;
  assign stall_cnt = '0;

  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
`endif

endmodule

// File: tb/tb_fifo_wr_skid.sv
`timescale 1ns/1ps
// Bench for fifo_wr_skid: a table of per-cycle vectors plus hand sequences, with
// a queue scoreboard of accepted words popped on each FIFO write.
// Two instances share stimulus: CNTW=16 and CNTW=4 for counter saturation.
module tb_fifo_wr_skid;

`ifdef WR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        wclk;
  logic        w_rstn;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        wfull;
  logic        clr_stats;

  logic        s_ready, winc, busy;
  logic [7:0]  wdata;
  logic [15:0] wr_cnt, stall_cnt;

  logic        s_ready_b, winc_b, busy_b;
  logic [7:0]  wdata_b;
  logic [3:0]  wr_cnt_b, stall_cnt_b;

  fifo_wr_skid #(.DATESIZE(8), .CNTW(16)) dut (
    .wclk(wclk), .w_rstn(w_rstn), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .busy(busy), .clr_stats(clr_stats), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
  );

  fifo_wr_skid #(.DATESIZE(8), .CNTW(4)) dut_b (
    .wclk(wclk), .w_rstn(w_rstn), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .winc(winc_b), .wdata(wdata_b), .wfull(wfull),
    .busy(busy_b), .clr_stats(clr_stats), .wr_cnt(wr_cnt_b), .stall_cnt(stall_cnt_b)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: accepted words in order, plus counter models.
  logic [7:0] sb[$];
  int wr_m = 0, st_m = 0, wr_m4 = 0, st_m4 = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic       rdy;
    logic       wi;
    logic [7:0] wd;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_rdy, exp_wi;
    exp_rdy = (sb.size() < 2);
    exp_wi  = (sb.size() != 0);
    chk("s_ready",   32'(s_ready),   32'(exp_rdy));
    chk("winc",      32'(winc),      32'(exp_wi));
    chk("busy",      32'(busy),      32'(exp_wi));
    chk("s_ready_b", 32'(s_ready_b), 32'(exp_rdy));
    chk("winc_b",    32'(winc_b),    32'(exp_wi));
    chk("busy_b",    32'(busy_b),    32'(exp_wi));
    if (exp_wi) begin
      chk("wdata",   32'(wdata),   32'(sb[0]));
      chk("wdata_b", 32'(wdata_b), 32'(sb[0]));
    end
    chk("wr_cnt",      32'(wr_cnt),      32'(wr_m));
    chk("stall_cnt",   32'(stall_cnt),   32'(st_m));
    chk("wr_cnt_b",    32'(wr_cnt_b),    32'(wr_m4));
    chk("stall_cnt_b", 32'(stall_cnt_b), 32'(st_m4));
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic f, input logic c);
    logic acc, wr, stl;
    acc = v && (sb.size() < 2);
    wr  = (sb.size() != 0) && !f;
    stl = (sb.size() != 0) && f;
    if (STATS) begin
      if (c) begin
        wr_m = 0; st_m = 0; wr_m4 = 0; st_m4 = 0;
      end else begin
        if (wr  && wr_m  < 65535) wr_m++;
        if (stl && st_m  < 65535) st_m++;
        if (wr  && wr_m4 < 15)    wr_m4++;
        if (stl && st_m4 < 15)    st_m4++;
      end
    end
    if (wr)  void'(sb.pop_front());
    if (acc) sb.push_back(d);
  endtask

  task automatic model_reset();
    sb.delete();
    wr_m = 0; st_m = 0; wr_m4 = 0; st_m4 = 0;
  endtask

  // Called just after a falling edge: check, drive, clock, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic c);
    check_outputs();
    s_valid   = v;
    s_data    = d;
    wfull     = f;
    clr_stats = c;
    @(posedge wclk);
    model_edge(v, d, f, c);
    @(negedge wclk);
  endtask

  initial begin
    // Backpressure then release, from EMPTY: only A0/A1 enter while full,
    // then A0, A1, A2 leave on consecutive edges (row 4 is accept+write in ONE).
    //          v     d      f     rdy   winc  wdata
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'hA0};
    tbl[2] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA0};
    tbl[3] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[4] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

    w_rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; wfull = 1'b0; clr_stats = 1'b0;
    #12;
    check_outputs();
    chk("rst_wdata", 32'(wdata), 32'h0);
    @(negedge wclk);
    w_rstn = 1'b1;

    // Stream: 0x01..0x10 back to back with wfull low.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stream_wr_cnt",   32'(wr_cnt),   STATS ? 32'd16 : 32'd0);
    chk("stream_wr_cnt_b", 32'(wr_cnt_b), STATS ? 32'd15 : 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      chk("tbl_s_ready", 32'(s_ready), 32'(tbl[i].rdy));
      chk("tbl_winc",    32'(winc),    32'(tbl[i].wi));
      if (tbl[i].wi) chk("tbl_wdata", 32'(wdata), 32'(tbl[i].wd));
      step(tbl[i].v, tbl[i].d, tbl[i].f, 1'b0);
    end

    // Reset while in TWO: outputs drop at once, buffered words are discarded.
    step(1'b1, 8'hB0, 1'b1, 1'b0);
    step(1'b1, 8'hB1, 1'b1, 1'b0);
    chk("pre_rst_ready", 32'(s_ready), 32'h0);
    #2 w_rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("mid_rst_wdata", 32'(wdata), 32'h0);
    @(negedge wclk);
    w_rstn = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("post_rst_wdata", 32'(wdata), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Saturation: 20 more writes, then clr_stats during a write.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sat_wr_cnt_b", 32'(wr_cnt_b), STATS ? 32'hF : 32'h0);
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b1);
    chk("clr_wr_cnt",   32'(wr_cnt),   32'h0);
    chk("clr_wr_cnt_b", 32'(wr_cnt_b), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_skid.md
FIFO_WR_SKID -- requirements
Module: fifo_wr_skid

Interface
REQ-001 Parameter DATESIZE, default 8, data word width; SHALL match the write-data width of the downstream async FIFO.
REQ-002 Parameter CNTW, default 16, width of the statistics counters.
REQ-003 wclk  input  1  write-domain clock; every register SHALL be clocked on its rising edge.
REQ-004 w_rstn  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_data  input  DATESIZE  upstream word.
REQ-007 s_ready  output  1  upstream may transfer; registered.
REQ-008 winc  output  1  FIFO write request.
REQ-009 wdata  output  DATESIZE  FIFO write data.
REQ-010 wfull  input  1  FIFO full flag; may assert asynchronously to wclk.
REQ-011 busy  output  1  buffer holds at least one word.
REQ-012 clr_stats  input  1  synchronous clear of the statistics counters.
REQ-013 wr_cnt  output  CNTW  count of words written to the FIFO (WR_STATS_EN only).
REQ-014 stall_cnt  output  CNTW  count of stalled write cycles (WR_STATS_EN only).

Function
REQ-015 Upstream accept SHALL occur at a wclk edge where s_valid=1 and s_ready=1.
REQ-016 FIFO write SHALL occur at a wclk edge where winc=1 and wfull=0, sampled at that edge, matching the FIFO's internal write gating.
REQ-017 The block SHALL implement a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-018 EMPTY SHALL go to ONE on accept and otherwise stay in EMPTY.
REQ-019 ONE SHALL go to TWO on accept without write, to EMPTY on write without accept, and otherwise stay in ONE; a simultaneous accept and write SHALL leave it in ONE.
REQ-020 TWO SHALL go to ONE on write and otherwise stay in TWO; no accept is possible in TWO.
REQ-021 s_ready SHALL be 1 exactly when the registered state is not TWO.
REQ-022 winc and busy SHALL be 1 exactly when the registered state is not EMPTY; winc SHALL NOT depend combinationally on s_valid or wfull.
REQ-023 wdata SHALL always present the oldest buffered word, and it SHALL stay stable while winc=1 and no write has occurred.
REQ-024 Words SHALL be written in acceptance order, with no loss and no duplication.
REQ-025 A word accepted at edge N SHALL appear on wdata after edge N; the earliest write of that word SHALL be at edge N+1.
REQ-026 With wfull=0 continuously and s_valid=1 continuously, throughput SHALL be one word per cycle.
REQ-027 With wfull=1 held, at most 2 words SHALL be accepted before s_ready falls.
REQ-028 When wfull deasserts, buffered words SHALL drain at one word per cycle.

Reset
REQ-029 Assertion of w_rstn=0 SHALL immediately force the state to EMPTY, winc=0, busy=0, s_ready=1, wr_cnt=0 and stall_cnt=0.
REQ-030 Words buffered when reset asserts mid-operation SHALL be discarded.
REQ-031 wdata SHALL be 0 after reset.
REQ-032 The first accept SHALL be possible at the first wclk edge after w_rstn deasserts.

Configuration
REQ-033 Macro WR_STATS_EN SHALL control the statistics counters.
REQ-034 With WR_STATS_EN defined, wr_cnt SHALL increment on each FIFO write.
REQ-035 With WR_STATS_EN defined, stall_cnt SHALL increment on each edge where winc=1 and wfull=1.
REQ-036 Both counters SHALL saturate at all-ones.
REQ-037 clr_stats=1 SHALL zero both counters at the next edge and SHALL take priority over an increment at that edge.
REQ-038 Without WR_STATS_EN, wr_cnt and stall_cnt SHALL be tied to 0, clr_stats SHALL be ignored, and no counter registers SHALL be synthesized.

Verification
REQ-039 Stream test: wfull=0; send 0x01..0x10 back-to-back -> 16 writes on 16 consecutive edges, wdata in order 0x01..0x10, s_ready constantly 1, wr_cnt=16.
REQ-040 Backpressure test: wfull=1 from the start; s_valid=1 with 0xA0,0xA1,0xA2 -> only 0xA0 and 0xA1 accepted, s_ready=0 from the cycle after the second accept, state TWO, stall_cnt increments every cycle.
REQ-041 Release test: from the previous scenario, drop wfull -> 0xA0, 0xA1, 0xA2 written on consecutive edges with no gap or duplicate.
REQ-042 Simultaneous accept and write in ONE with wfull=0 -> state stays ONE, wdata advances to the new word.
REQ-043 Reset test: assert w_rstn=0 while in TWO -> winc=0 and s_ready=1 immediately, counters 0; after release, next word 0x55 is written with no stale data.
REQ-044 Saturation test: CNTW=4, WR_STATS_EN defined; 20 writes -> wr_cnt holds 0xF; clr_stats during a write -> 0 next cycle.
